// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the lap stopwatch.
package stopwatch_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned TICK_HZ = 100;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_LAP_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sw_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-window debouncer and
// a single-cycle pulse on each debounced press.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 320000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with start/stop, clear and lap/split hold of the display.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32000000,
  parameter int unsigned NDIG       = 4,
  parameter int unsigned DEB_CYCLES = 320000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_start,
  input  logic                  sw_clear,
  input  logic                  sw_lap,
  output logic [BCD_W*NDIG-1:0] bcd_out,
  output logic                  running,
  output logic                  hold,
  output logic                  ovf
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);
  localparam int unsigned CW       = BCD_W * NDIG;

  logic start_p, clear_p, lap_p;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .sw_i(sw_start), .press_o(start_p)
  );
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .rst(rst), .sw_i(sw_clear), .press_o(clear_p)
  );
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .sw_i(sw_lap), .press_o(lap_p)
  );

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CW-1:0]    cnt_q, cnt_d, snap_q, snap_d, cnt_inc, bcd_q;
  logic             hold_q, hold_d, ovf_q, ovf_d, run_q;
  logic             carry_all, tick;

  // Ripple-carry BCD increment; carry_all marks the all-9s wrap.
  always_comb begin
    cnt_inc   = cnt_q;
    carry_all = 1'b1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (carry_all) begin
        if (cnt_q[k*BCD_W +: BCD_W] == BCD_W'(9)) begin
          cnt_inc[k*BCD_W +: BCD_W] = '0;
        end else begin
          cnt_inc[k*BCD_W +: BCD_W] = cnt_q[k*BCD_W +: BCD_W] + BCD_W'(1);
          carry_all = 1'b0;
        end
      end
    end
  end

  assign tick = (state_q != ST_STOPPED) && (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;

    if (state_q != ST_STOPPED) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
    if (tick) begin
      cnt_d = cnt_inc;
      if (carry_all) ovf_d = 1'b1;
    end

    // Priority clear > start > lap; a losing pulse is dropped even if the winner is ignored.
    if (clear_p) begin
      if (state_q == ST_STOPPED) begin
        cnt_d  = '0;
        snap_d = '0;
        pre_d  = '0;
        hold_d = 1'b0;
        ovf_d  = 1'b0;
      end
    end else if (start_p) begin
      case (state_q)
        ST_STOPPED: begin
          state_d = ST_RUNNING;
          hold_d  = 1'b0;
        end
        ST_RUNNING:  state_d = ST_STOPPED;
        ST_LAP_HOLD: state_d = ST_STOPPED;
        default:     state_d = ST_STOPPED;
      endcase
    end else if (lap_p) begin
      case (state_q)
        ST_RUNNING: begin
          state_d = ST_LAP_HOLD;
          hold_d  = 1'b1;
          snap_d  = cnt_d;
        end
        ST_LAP_HOLD: snap_d = cnt_d;
        ST_STOPPED:  hold_d = 1'b0;
        default:     state_d = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      pre_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      hold_q  <= 1'b0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      run_q   <= (state_d != ST_STOPPED);
      bcd_q   <= hold_q ? snap_q : cnt_q;
    end
  end

  assign bcd_out = bcd_q;
  assign running = run_q;
  assign hold    = hold_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: cycle reference model for the main instance,
// plus a fast-tick instance for the full 9999 -> 0000 wrap.
module tb_stopwatch_lap;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned NDIG     = 4;
  localparam int unsigned DEB      = 4;
  localparam int          TDIV     = CLK_FREQ / 100;
  localparam int          MODV     = 10000;

  logic clk = 1'b0;
  logic rst, sw_start, sw_clear, sw_lap;
  logic [15:0] bcd_out;
  logic running, hold, ovf;
  logic w_start, w_clear, w_lap;
  logic [15:0] w_bcd;
  logic w_run, w_hold, w_ovf;

  stopwatch_lap #(.CLK_FREQ(CLK_FREQ), .NDIG(NDIG), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw_start(sw_start), .sw_clear(sw_clear), .sw_lap(sw_lap),
    .bcd_out(bcd_out), .running(running), .hold(hold), .ovf(ovf)
  );

  stopwatch_lap #(.CLK_FREQ(200), .NDIG(NDIG), .DEB_CYCLES(DEB)) dut_wrap (
    .clk(clk), .rst(rst), .sw_start(w_start), .sw_clear(w_clear), .sw_lap(w_lap),
    .bcd_out(w_bcd), .running(w_run), .hold(w_hold), .ovf(w_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed time as plain integers, buttons as sample histories.
  int          m_count, m_frac, m_snap;
  bit          m_run, m_hold, m_ovf;
  logic [15:0] m_disp;
  bit          hist [3][6];
  bit          lvl  [3];
  bit          pend [3];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int d = 0; d < 4; d++) begin
      if (v[d*4 +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_count = 0; m_frac = 0; m_snap = 0;
    m_run = 0; m_hold = 0; m_ovf = 0; m_disp = '0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 0; pend[b] = 0;
      for (int i = 0; i < 6; i++) hist[b][i] = 0;
    end
  endtask

  task automatic model_edge();
    bit pc, ps, pl, st;
    bit raw [3];
    if (rst) begin
      model_reset();
      return;
    end
    pc = pend[0]; ps = pend[1]; pl = pend[2];
    raw[0] = sw_clear; raw[1] = sw_start; raw[2] = sw_lap;
    for (int b = 0; b < 3; b++) begin
      for (int i = 5; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = raw[b];
      st = 1;
      for (int i = 2; i < 6; i++) if (hist[b][i] == lvl[b]) st = 0;
      pend[b] = 0;
      if (st) begin
        lvl[b]  = ~lvl[b];
        pend[b] = lvl[b];
      end
    end
    m_disp = m_hold ? to_bcd(m_snap) : to_bcd(m_count);
    if (m_run) begin
      if (m_frac == TDIV - 1) begin
        m_frac  = 0;
        m_count = m_count + 1;
        if (m_count == MODV) begin
          m_count = 0;
          m_ovf   = 1;
        end
      end else begin
        m_frac = m_frac + 1;
      end
    end
    if (pc) begin
      if (!m_run) begin
        m_count = 0; m_snap = 0; m_frac = 0; m_hold = 0; m_ovf = 0;
      end
    end else if (ps) begin
      if (!m_run) begin
        m_run = 1; m_hold = 0;
      end else begin
        m_run = 0;
      end
    end else if (pl) begin
      if (m_run) begin
        m_hold = 1; m_snap = m_count;
      end else begin
        m_hold = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("bcd_out", 32'(bcd_out), 32'(m_disp));
    chk("running", 32'(running), 32'(m_run));
    chk("hold", 32'(hold), 32'(m_hold));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: sw_clear = v;
      1: sw_start = v;
      2: sw_lap   = v;
      3: w_start  = v;
      4: w_clear  = v;
      default: w_lap = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    repeat (10) cyc();
    set_btn(b, 1'b0);
    repeat (10) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_main(input logic [15:0] tgt, input string tag);
    int n;
    n = 0;
    while (!(to_bcd(m_count) == tgt && m_frac == 0) && n < 20000) begin
      cyc();
      n++;
    end
    checks++;
    assert (n < 20000) else begin
      errors++;
      $error("FAIL %s timeout observed %h expected %h", tag, to_bcd(m_count), tgt);
    end
  endtask

  task automatic wait_wrap(input logic [15:0] tgt, input int limit, input string tag);
    int n;
    n = 0;
    while (w_bcd !== tgt && n < limit) begin
      cyc();
      chk("w_nibble", 32'(bcd_ok(w_bcd)), 32'd1);
      n++;
    end
    checks++;
    assert (n < limit) else begin
      errors++;
      $error("FAIL %s timeout observed %h expected %h", tag, w_bcd, tgt);
    end
  endtask

  initial begin
    rst = 1'b1; sw_start = 0; sw_clear = 0; sw_lap = 0;
    w_start = 0; w_clear = 0; w_lap = 0;
    model_reset();
    repeat (3) cyc();
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_w_bcd", 32'(w_bcd), 32'd0);
    rst = 1'b0;

    // Debounce: a 3-cycle glitch is rejected, a stable level starts the watch after 7 edges.
    sw_start = 1;
    repeat (3) cyc();
    sw_start = 0;
    repeat (12) cyc();
    chk("glitch_norun", 32'(running), 32'd0);
    sw_start = 1;
    repeat (6) cyc();
    chk("deb_early", 32'(running), 32'd0);
    cyc();
    chk("deb_rise", 32'(running), 32'd1);
    repeat (3) cyc();
    sw_start = 0;
    repeat (12) cyc();
    chk("deb_single", 32'(running), 32'd1);

    // Counting: 1.00 s then stop holds the value.
    do_reset();
    sw_start = 1;
    repeat (7) cyc();
    chk("cnt_started", 32'(running), 32'd1);
    for (int i = 0; i < 1001; i++) begin
      if (i == 3) sw_start = 0;
      cyc();
    end
    chk("count_1s", 32'(bcd_out), 32'h0100);
    press_btn(1);
    chk("stopped", 32'(running), 32'd0);
    for (int i = 0; i < 500; i++) begin
      cyc();
      chk("stop_const", 32'(bcd_out), 32'h0100);
    end

    // Lap and split.
    do_reset();
    press_btn(1);
    wait_main(16'h0042, "reach_42");
    press_btn(2);
    chk("lap_frozen", 32'(bcd_out), 32'h0042);
    chk("lap_hold", 32'(hold), 32'd1);
    chk("lap_advancing", 32'(to_bcd(m_count) != 16'h0042), 32'd1);
    wait_main(16'h0057, "reach_57");
    press_btn(2);
    chk("split", 32'(bcd_out), 32'h0057);
    press_btn(1);
    chk("stop_keeps_hold", 32'(hold), 32'd1);
    chk("stop_keeps_bcd", 32'(bcd_out), 32'h0057);
    chk("stop_not_running", 32'(running), 32'd0);
    press_btn(2);
    chk("unhold", 32'(hold), 32'd0);
    chk("unhold_tracks", 32'(bcd_out), 32'(to_bcd(m_count)));

    // Start and lap together: only start acts.
    do_reset();
    sw_start = 1; sw_lap = 1;
    repeat (7) cyc();
    chk("simul_run", 32'(running), 32'd1);
    chk("simul_nohold", 32'(hold), 32'd0);
    repeat (3) cyc();
    sw_start = 0; sw_lap = 0;
    repeat (12) cyc();
    chk("simul_nohold2", 32'(hold), 32'd0);

    // Reset mid-count with a lap press mid-debounce.
    wait_main(16'h0315, "reach_315");
    cyc();
    chk("pre_rst_bcd", 32'(bcd_out), 32'h0315);
    sw_lap = 1;
    repeat (4) cyc();
    rst = 1; sw_lap = 0;
    cyc();
    chk("rst_mid_bcd", 32'(bcd_out), 32'd0);
    chk("rst_mid_run", 32'(running), 32'd0);
    chk("rst_mid_hold", 32'(hold), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    rst = 0;
    repeat (20) cyc();
    chk("post_rst_run", 32'(running), 32'd0);
    chk("post_rst_hold", 32'(hold), 32'd0);
    chk("post_rst_bcd", 32'(bcd_out), 32'd0);

    // Wrap 9999 -> 0000 on the fast-tick instance, then clear rules.
    press_btn(3);
    chk("w_running", 32'(w_run), 32'd1);
    wait_wrap(16'h9999, 25000, "reach_9999");
    chk("w_ovf_pre", 32'(w_ovf), 32'd0);
    wait_wrap(16'h0000, 10, "reach_wrap");
    chk("w_ovf_set", 32'(w_ovf), 32'd1);
    press_btn(4);
    chk("w_clr_ign_run", 32'(w_run), 32'd1);
    chk("w_clr_ign_ovf", 32'(w_ovf), 32'd1);
    chk("w_clr_ign_bcd", 32'(w_bcd != 16'h0000), 32'd1);
    press_btn(3);
    chk("w_stopped", 32'(w_run), 32'd0);
    press_btn(4);
    chk("w_clear_bcd", 32'(w_bcd), 32'd0);
    chk("w_clear_ovf", 32'(w_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 32000000, meaning clk frequency in Hz; TICK_DIV = CLK_FREQ/100 (10 ms tick), legal only if CLK_FREQ is a multiple of 100 and >= 200.
REQ-002 SHALL have parameter NDIG, default 4, meaning BCD digit count, legal range 2..8; digit 0 = 10 ms units.
REQ-003 SHALL have parameter DEB_CYCLES, default 320000, meaning debounce stability window in clk cycles, legal range >= 2.
REQ-004 SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port sw_start, input, width 1: raw start/stop button, active high, asynchronous to clk.
REQ-007 SHALL have port sw_clear, input, width 1: raw clear button, same properties as sw_start.
REQ-008 SHALL have port sw_lap, input, width 1: raw lap/split button, same properties as sw_start.
REQ-009 SHALL have port bcd_out, output, width 4*NDIG: displayed time, digit k at bits [4k+3:4k].
REQ-010 SHALL have port running, output, width 1: high while counting.
REQ-011 SHALL have port hold, output, width 1: high while bcd_out shows a frozen lap value.
REQ-012 SHALL have port ovf, output, width 1: sticky flag, high once the count has wrapped.

Function
REQ-013 SHALL pass each sw_* input through a 2-flop synchroniser and then a debouncer whose level changes only after the synchronised input has been stable for DEB_CYCLES consecutive clocks.
REQ-014 SHALL derive a 1-cycle press pulse from each debounced rising edge; releases generate nothing.
REQ-015 SHALL apply priority clear > start > lap when pulses coincide; lower-priority pulses in the same cycle are discarded.
REQ-016 SHALL use states STOPPED, RUNNING and LAP_HOLD, with running = 1 in RUNNING and LAP_HOLD, and hold = 1 in LAP_HOLD.
REQ-017 SHALL make these transitions:
- STOPPED + start -> RUNNING.
- RUNNING + start -> STOPPED.
- RUNNING + lap -> LAP_HOLD, capturing the snapshot.
- LAP_HOLD + lap -> LAP_HOLD, recapturing the snapshot (split).
- LAP_HOLD + start -> STOPPED, with hold kept (frozen display retained).
- STOPPED + lap with hold=1 -> hold cleared.
REQ-018 SHALL treat clear as follows:
- Ignored in RUNNING and LAP_HOLD.
- In STOPPED, zeroes the count, snapshot, prescaler, hold and ovf in one cycle.
REQ-019 SHALL advance the prescaler 0..TICK_DIV-1 only while running=1; it freezes (fraction preserved) while stopped.
REQ-020 SHALL increment the NDIG-digit BCD count on the clock edge where the prescaler goes TICK_DIV-1 -> 0, with ripple carry through all digits in the same cycle; every digit wraps 9 -> 0.
REQ-021 SHALL wrap an all-9s count to all-0s and set ovf; counting continues and ovf stays set until clear or rst.
REQ-022 SHALL register bcd_out = hold ? snapshot : count, one cycle after the internal value changes.
REQ-023 SHALL capture into the snapshot the count value in the same cycle as the lap pulse, including an increment committed that cycle.
REQ-024 SHALL never produce a non-BCD nibble (A-F) on bcd_out.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force state STOPPED, count = 0, snapshot = 0, prescaler = 0, bcd_out = 0, running = 0, hold = 0, ovf = 0, and clear all debouncer levels and counters.
REQ-026 SHALL make rst override all button activity, including mid-count and mid-debounce; no press pulse may emerge from a debounce in progress when rst is asserted.

Structure
REQ-027 SHALL place in shared package stopwatch_pkg the BCD digit width (4), the state encoding STOPPED/RUNNING/LAP_HOLD, and the 10 ms tick rate constant (100 Hz).
REQ-028 SHALL instantiate sub-module sw_debounce three times; each instance contains the synchroniser, stability counter and rising-edge pulse, parameterised by DEB_CYCLES.
REQ-029 SHALL keep the prescaler, BCD counter, snapshot register and state machine in stopwatch_lap itself, with no further sub-modules.

Verification
REQ-030 SHALL run all scenarios with bench parameters CLK_FREQ=1000 (TICK_DIV=10), NDIG=4, DEB_CYCLES=4.
REQ-031 SHALL cover debounce: sw_start glitching high for 3 cycles, then stable for 10 cycles -> exactly one start pulse, and running rises 2+4+1 cycles after the stable level.
REQ-032 SHALL cover counting: start, then 1000 clocks -> bcd_out = 0x0100 (1.00 s), after which stop holds the value constant for 500 further clocks.
REQ-033 SHALL cover lap/split: lap pressed at count 0x0042 -> bcd_out frozen at 0x0042 while the internal count advances; second lap at 0x0057 -> bcd_out = 0x0057; stop followed by lap -> bcd_out tracks the count.
REQ-034 SHALL cover wrap and clear: preload via running to 0x9999, then one more tick -> bcd_out = 0x0000 and ovf = 1; clear while running ignored; stop then clear -> bcd_out = 0, ovf = 0.
REQ-035 SHALL cover simultaneous events and reset: start and lap pulses coinciding -> only start acts; rst asserted mid-count at 0x0315 -> all outputs 0 on the next edge, and no spurious pulse after rst deasserts.
